// File: rtl/rv32i_top.sv
// Single-cycle RV32I core with internal instruction memory and data memory (instance data_mem).
// Define RV32I_TRACE_EN to compile a simulation-only per-instruction retire trace.

module rv32i_dmem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata_c
);
  logic [31:0] mem [DEPTH];

  // Zero at time 0 only; reset leaves contents alone.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata_c = mem[i_idx];
endmodule

module rv32i_top #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_INIT  = "program.hex"
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;

  logic [31:0] r_pc;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_regs [32];

  logic [31:0] w_instr;
  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_alt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1v, w_rs2v, w_opb, w_alu, w_addr, w_rdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_taken;
  logic [31:0] w_next_pc, w_rd_data, w_wdata;
  logic        w_rd_we, w_st_we;
  logic [3:0]  w_be;
  logic        w_unused;

  assign w_instr = r_imem[r_pc[IAW+1:2]];
  assign w_op    = w_instr[6:0];
  assign w_rd    = w_instr[11:7];
  assign w_f3    = w_instr[14:12];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];
  assign w_alt   = w_instr[30];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'd0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_rs1v = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2v = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
  assign w_opb  = (w_op == OP_REG) ? w_rs2v : w_imm_i;
  assign w_addr = w_rs1v + ((w_op == OP_ST) ? w_imm_s : w_imm_i);

  assign w_ld_byte = 8'(w_rdata >> {w_addr[1:0], 3'b000});
  assign w_ld_half = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
  assign w_unused  = ^w_addr[31:DAW+2];

  // Shared ALU for OP and OP-IMM; SUB only exists in register form.
  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'd0: w_alu = (w_op == OP_REG && w_alt) ? w_rs1v - w_opb : w_rs1v + w_opb;
      3'd1: w_alu = w_rs1v << w_opb[4:0];
      3'd2: w_alu = {31'd0, $signed(w_rs1v) < $signed(w_opb)};
      3'd3: w_alu = {31'd0, w_rs1v < w_opb};
      3'd4: w_alu = w_rs1v ^ w_opb;
      3'd5: w_alu = w_alt ? 32'($signed(w_rs1v) >>> w_opb[4:0]) : w_rs1v >> w_opb[4:0];
      3'd6: w_alu = w_rs1v | w_opb;
      default: w_alu = w_rs1v & w_opb;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'd0: w_taken = (w_rs1v == w_rs2v);
      3'd1: w_taken = (w_rs1v != w_rs2v);
      3'd4: w_taken = ($signed(w_rs1v) < $signed(w_rs2v));
      3'd5: w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
      3'd6: w_taken = (w_rs1v < w_rs2v);
      3'd7: w_taken = (w_rs1v >= w_rs2v);
      default: w_taken = 1'b0;
    endcase
  end

  // Decode/writeback control; anything unrecognised falls through as a NOP.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_rd_we   = 1'b0;
    w_rd_data = w_alu;
    w_st_we   = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = w_rs2v;
    case (w_op)
      OP_LUI:   begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
      OP_AUIPC: begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
      OP_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + 32'd4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + 32'd4;
        w_next_pc = (w_rs1v + w_imm_i) & ~32'd1;
      end
      OP_BR: if (w_taken) w_next_pc = r_pc + w_imm_b;
      OP_LD: begin
        case (w_f3)
          3'd0: begin w_rd_we = 1'b1; w_rd_data = {{24{w_ld_byte[7]}}, w_ld_byte}; end
          3'd1: begin w_rd_we = 1'b1; w_rd_data = {{16{w_ld_half[15]}}, w_ld_half}; end
          3'd2: begin w_rd_we = 1'b1; w_rd_data = w_rdata; end
          3'd4: begin w_rd_we = 1'b1; w_rd_data = {24'd0, w_ld_byte}; end
          3'd5: begin w_rd_we = 1'b1; w_rd_data = {16'd0, w_ld_half}; end
          default: w_rd_we = 1'b0;
        endcase
      end
      OP_ST: begin
        case (w_f3)
          3'd0: begin w_st_we = 1'b1; w_be = 4'b0001 << w_addr[1:0]; w_wdata = {4{w_rs2v[7:0]}}; end
          3'd1: begin w_st_we = 1'b1; w_be = w_addr[1] ? 4'b1100 : 4'b0011; w_wdata = {2{w_rs2v[15:0]}}; end
          3'd2: begin w_st_we = 1'b1; w_be = 4'b1111; end
          default: w_st_we = 1'b0;
        endcase
      end
      OP_IMM, OP_REG: w_rd_we = 1'b1;
      default: w_rd_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= '0;
    else     r_pc <= w_next_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_data;
  end

  rv32i_dmem #(.DEPTH(DMEM_DEPTH)) data_mem (
    .clk       (clk),
    .i_we      (w_st_we & ~rst),
    .i_be      (w_be),
    .i_idx     (w_addr[DAW+1:2]),
    .i_wdata   (w_wdata),
    .o_rdata_c (w_rdata)
  );

`ifdef RV32I_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_rd_we && w_rd != 5'd0)
        $display("trace pc=%08h ins=%08h x%0d<=%08h", r_pc, w_instr, w_rd, w_rd_data);
      else if (w_st_we)
        $display("trace pc=%08h ins=%08h st [%08h]<=%08h be=%b", r_pc, w_instr, w_addr, w_wdata, w_be);
      else
        $display("trace pc=%08h ins=%08h", r_pc, w_instr);
    end
  end
`else
  // Trace disabled: no simulation-only logic compiled.
`endif
endmodule

// File: tb/tb_rv32i_top.sv
// Bench for rv32i_top: directed program table, reset sequences and random
// programs checked against an instruction-level reference interpreter.

module tb_rv32i_top;
  localparam int IMEM_D = 256;
  localparam int DMEM_D = 256;
  localparam int MB     = DMEM_D * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_top #(.IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D), .IMEM_INIT("")) dut (
    .clk (clk),
    .rst (rst)
  );

  int total = 0;
  int bad   = 0;

  // Reference machine state: byte-addressed little-endian memory.
  logic [31:0] m_imem [IMEM_D];
  logic [31:0] m_x    [32];
  logic [7:0]  m_mem  [MB];
  logic [31:0] m_pc;
  logic [31:0] pq [$];

  typedef struct {
    logic [15:0][31:0] prog;
    int unsigned       len;
    int unsigned       cycles;
    logic [3:0][7:0]   idx;
    logic [3:0][31:0]  exp;
    int unsigned       nchk;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] e_i(int op, int rd, int f3, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] e_r(int f7, int rd, int f3, int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] e_s(int f3, int rs2, int rs1, int imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(int f3, int rs1, int rs2, int imm);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_u(int op, int rd, int imm20);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] e_j(int rd, int imm);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm); return e_i(7'h13, rd, 0, rs1, imm); endfunction
  function automatic logic [31:0] sw(int rs2, int imm); return e_s(2, rs2, 0, imm); endfunction

  function automatic logic [31:0] m_load(logic [31:0] a, int n);
    int unsigned base;
    logic [31:0] v;
    base = a % MB;
    base = base - base % n;
    v = '0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | 32'(m_mem[base + i]);
    return v;
  endfunction

  task automatic m_store(logic [31:0] a, int n, logic [31:0] v);
    int unsigned base;
    base = a % MB;
    base = base - base % n;
    for (int i = 0; i < n; i++) m_mem[base + i] = 8'(v >> (8 * i));
  endtask

  // One instruction of the ISA, evaluated directly from its definition.
  task automatic model_step();
    logic [31:0] ins, a, b, op2, ii, is, ib, iu, ij, res, npc, ad;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, take;
    ins = m_imem[(m_pc >> 2) % IMEM_D];
    a = m_x[ins[19:15]];
    b = m_x[ins[24:20]];
    rd = ins[11:7];
    f3 = ins[14:12];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4;
    wr = 1'b0;
    res = '0;
    take = 1'b0;
    case (ins[6:0])
      7'h37: begin wr = 1; res = iu; end
      7'h17: begin wr = 1; res = m_pc + iu; end
      7'h6f: begin wr = 1; res = m_pc + 4; npc = m_pc + ij; end
      7'h67: begin wr = 1; res = m_pc + 4; npc = (a + ii) & 32'hffff_fffe; end
      7'h63: begin
        case (f3)
          0: take = (a == b);
          1: take = (a != b);
          4: take = ($signed(a) < $signed(b));
          5: take = !($signed(a) < $signed(b));
          6: take = (a < b);
          7: take = !(a < b);
          default: take = 0;
        endcase
        if (take) npc = m_pc + ib;
      end
      7'h03: begin
        ad = a + ii;
        wr = 1;
        case (f3)
          0: res = 32'($signed(8'(m_load(ad, 1))));
          1: res = 32'($signed(16'(m_load(ad, 2))));
          2: res = m_load(ad, 4);
          4: res = m_load(ad, 1);
          5: res = m_load(ad, 2);
          default: wr = 0;
        endcase
      end
      7'h23: begin
        ad = a + is;
        if (f3 == 0) m_store(ad, 1, b);
        else if (f3 == 1) m_store(ad, 2, b);
        else if (f3 == 2) m_store(ad, 4, b);
      end
      7'h13, 7'h33: begin
        op2 = (ins[6:0] == 7'h33) ? b : ii;
        wr = 1;
        case (f3)
          0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - op2 : a + op2;
          1: res = a << (op2 % 32);
          2: res = ($signed(a) < $signed(op2)) ? 1 : 0;
          3: res = (a < op2) ? 1 : 0;
          4: res = a ^ op2;
          5: res = ins[30] ? 32'($signed(a) >>> (op2 % 32)) : a >> (op2 % 32);
          6: res = a | op2;
          default: res = a & op2;
        endcase
      end
      default: wr = 0;
    endcase
    if (wr && rd != 0) m_x[rd] = res;
    m_pc = npc;
  endtask

  task automatic load_pq();
    logic [31:0] w;
    for (int i = 0; i < IMEM_D; i++) begin
      w = (i < pq.size()) ? pq[i] : 32'd0;
      dut.r_imem[i] = w;
      m_imem[i] = w;
    end
  endtask

  task automatic apply_reset(int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_pc = '0;
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
    end
    #1;
  endtask

  task automatic vp(int k, logic [31:0] w);
    vecs[k].prog[vecs[k].len] = w;
    vecs[k].len++;
  endtask
  task automatic vc(int k, int idx, logic [31:0] e);
    vecs[k].idx[vecs[k].nchk] = 8'(idx);
    vecs[k].exp[vecs[k].nchk] = e;
    vecs[k].nchk++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int i = 0; i < MB; i++) m_mem[i] = '0;
    m_pc = '0;
    for (int k = 0; k < 7; k++) begin
      vecs[k].prog = '0; vecs[k].len = 0; vecs[k].cycles = 40;
      vecs[k].idx = '0; vecs[k].exp = '0; vecs[k].nchk = 0;
    end

    // 0: add and store
    vp(0, addi(1, 0, 5)); vp(0, addi(2, 0, 7)); vp(0, e_r(0, 3, 0, 1, 2)); vp(0, sw(3, 0));
    vecs[0].cycles = 98; vc(0, 0, 32'h0000_000c);
    // 1: byte load sign/zero extension
    vp(1, addi(1, 0, -1)); vp(1, sw(1, 4)); vp(1, e_i(3, 2, 0, 0, 4)); vp(1, e_i(3, 3, 4, 0, 4));
    vp(1, sw(2, 8)); vp(1, sw(3, 12));
    vc(1, 1, 32'hffff_ffff); vc(1, 2, 32'hffff_ffff); vc(1, 3, 32'h0000_00ff);
    // 2: bne loop with counter
    vp(2, addi(1, 0, 3)); vp(2, addi(2, 0, 0)); vp(2, addi(1, 1, -1)); vp(2, addi(2, 2, 1));
    vp(2, e_b(1, 1, 0, -8)); vp(2, sw(1, 0)); vp(2, sw(2, 4));
    vc(2, 0, 32'h0); vc(2, 1, 32'h3);
    // 3: lui/addi with halfword and byte lane stores
    vp(3, e_u(7'h37, 1, 20'h12345)); vp(3, addi(1, 1, 12'h678)); vp(3, e_s(1, 1, 0, 2)); vp(3, e_s(0, 1, 0, 0));
    vc(3, 0, 32'h5678_0078);
    // 4: x0 stays zero, jal links and skips
    vp(4, addi(0, 0, 9)); vp(4, sw(0, 0)); vp(4, e_j(5, 8)); vp(4, addi(6, 0, 1)); vp(4, sw(5, 4));
    vc(4, 0, 32'h0); vc(4, 1, 32'h0000_000c);
    // 5: shifts, slt, sub
    vp(5, addi(1, 0, -8)); vp(5, e_i(7'h13, 2, 5, 1, 1024 + 1)); vp(5, e_i(7'h13, 3, 5, 1, 28));
    vp(5, e_r(0, 4, 2, 1, 0)); vp(5, e_r(32, 5, 0, 0, 1));
    vp(5, sw(2, 24)); vp(5, sw(3, 28)); vp(5, sw(4, 32)); vp(5, sw(5, 36));
    vc(5, 6, 32'hffff_fffc); vc(5, 7, 32'h0000_000f); vc(5, 8, 32'h1); vc(5, 9, 32'h8);
    // 6: jalr with odd target, bltu taken, bge not taken
    vp(6, addi(1, 0, 17)); vp(6, e_i(7'h67, 2, 0, 1, 0)); vp(6, sw(1, 44)); vp(6, sw(1, 44));
    vp(6, sw(2, 40)); vp(6, addi(4, 0, -1)); vp(6, e_b(6, 0, 4, 8)); vp(6, sw(4, 44));
    vp(6, e_b(5, 4, 0, 8)); vp(6, sw(1, 48));
    vc(6, 10, 32'h8); vc(6, 11, 32'h0); vc(6, 12, 32'h11);

    #1;
    apply_reset(2);
    chk("reset_pc", dut.r_pc, 32'h0);
    for (int k = 0; k < 7; k++) begin
      pq.delete();
      for (int i = 0; i < int'(vecs[k].len); i++) pq.push_back(vecs[k].prog[i]);
      load_pq();
      apply_reset(2);
      run(int'(vecs[k].cycles));
      for (int c = 0; c < int'(vecs[k].nchk); c++)
        chk($sformatf("vec%0d_mem%0d", k, vecs[k].idx[c]),
            dut.data_mem.mem[vecs[k].idx[c]], vecs[k].exp[c]);
    end

    // Mid-run reset on the add program: restart from 0, memory retained.
    pq.delete();
    pq.push_back(addi(1, 0, 5)); pq.push_back(addi(2, 0, 7));
    pq.push_back(e_r(0, 3, 0, 1, 2)); pq.push_back(sw(3, 0));
    load_pq();
    apply_reset(2);
    run(1);
    chk("first_retire_pc", dut.r_pc, 32'h4);
    run(97);
    chk("rerun_mem0_before", dut.data_mem.mem[0], 32'h0000_000c);
    run(5);
    apply_reset(1);
    chk("midrun_reset_pc", dut.r_pc, 32'h0);
    chk("midrun_mem0_kept", dut.data_mem.mem[0], 32'h0000_000c);
    run(20);
    chk("rerun_mem0_after", dut.data_mem.mem[0], 32'h0000_000c);

    // Memory counter: each full pass increments; a pass cut by reset before its store does not.
    pq.delete();
    pq.push_back(e_i(3, 1, 2, 0, 64)); pq.push_back(addi(1, 1, 1)); pq.push_back(sw(1, 64));
    load_pq();
    apply_reset(2);
    run(10);
    chk("counter_pass1", dut.data_mem.mem[16], 32'h1);
    apply_reset(1);
    run(2);
    apply_reset(1);
    run(10);
    chk("counter_pass2", dut.data_mem.mem[16], 32'h2);
    apply_reset(1);
    run(10);
    chk("counter_pass3", dut.data_mem.mem[16], 32'h3);

    // Random ALU/load/store programs against the reference interpreter.
    for (int t = 0; t < 8; t++) begin
      int sel;
      pq.delete();
      for (int r = 1; r < 8; r++) begin
        pq.push_back(e_u(7'h37, r, int'($urandom)));
        pq.push_back(addi(r, r, int'($urandom_range(0, 4095)) - 2048));
      end
      for (int n = 0; n < 12; n++) begin
        int rd, rs1, rs2;
        rd = int'($urandom_range(1, 7)); rs1 = int'($urandom_range(1, 7)); rs2 = int'($urandom_range(1, 7));
        sel = int'($urandom_range(0, 18));
        case (sel)
          0:  pq.push_back(e_r(0, rd, 0, rs1, rs2));
          1:  pq.push_back(e_r(32, rd, 0, rs1, rs2));
          2:  pq.push_back(e_r(0, rd, 1, rs1, rs2));
          3:  pq.push_back(e_r(0, rd, 2, rs1, rs2));
          4:  pq.push_back(e_r(0, rd, 3, rs1, rs2));
          5:  pq.push_back(e_r(0, rd, 4, rs1, rs2));
          6:  pq.push_back(e_r(0, rd, 5, rs1, rs2));
          7:  pq.push_back(e_r(32, rd, 5, rs1, rs2));
          8:  pq.push_back(e_r(0, rd, 6, rs1, rs2));
          9:  pq.push_back(e_r(0, rd, 7, rs1, rs2));
          10: pq.push_back(e_i(7'h13, rd, 1, rs1, int'($urandom_range(0, 31))));
          11: pq.push_back(e_i(7'h13, rd, 5, rs1, int'($urandom_range(0, 31))));
          12: pq.push_back(e_i(7'h13, rd, 5, rs1, 1024 + int'($urandom_range(0, 31))));
          default: begin
            int f3s [6] = '{0, 2, 3, 4, 6, 7};
            pq.push_back(e_i(7'h13, rd, f3s[sel - 13], rs1, int'($urandom_range(0, 4095)) - 2048));
          end
        endcase
      end
      for (int n = 0; n < 4; n++) begin
        int lf3 [5] = '{0, 1, 2, 4, 5};
        pq.push_back(e_s(int'($urandom_range(0, 2)), int'($urandom_range(1, 7)), 0, 128 + int'($urandom_range(0, 31))));
        pq.push_back(e_i(3, int'($urandom_range(1, 7)), lf3[$urandom_range(0, 4)], 0, 128 + int'($urandom_range(0, 31))));
      end
      for (int r = 1; r < 8; r++) pq.push_back(sw(r, 192 + 4 * (r - 1)));
      load_pq();
      apply_reset(2);
      run(pq.size() + 4);
      for (int w = 32; w < 56; w++)
        chk($sformatf("rand%0d_mem%0d", t, w), dut.data_mem.mem[w],
            {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
